// File: rtl/eth_pcs_block_sync.sv
// RX PCS block-lock: clause 49 sync-header lock FSM with gearbox slip requests
// and a saturating invalid-header counter. High-BER monitor built only with ETH_PCS_BLOCK_SYNC_HI_BER_EN.
module eth_pcs_block_sync #(
  parameter int W_SYNC         = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVLD_MAX   = 16,
  parameter int SLIP_WAIT_HDRS = 2,
  parameter int BER_WIN_HDRS   = 19531,
  parameter int BER_THRESH     = 16,
  parameter int W_ERR_CNT      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_clk_en,
  input  logic                 i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0]    i_grbx_hdr,
  input  logic                 i_cnt_clr,
  output logic                 o_grbx_slip,
  output logic                 o_block_lock,
  output logic                 o_hi_ber,
  output logic [W_ERR_CNT-1:0] o_invld_hdr_cnt
);

  localparam logic [1:0] ST_RESET_CNT = 2'd0;
  localparam logic [1:0] ST_TEST_SH   = 2'd1;
  localparam logic [1:0] ST_SLIP      = 2'd2;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd3;

  localparam int W_WAIT = $clog2(SLIP_WAIT_HDRS + 1);

  localparam logic [6:0]        SH_MAX_C    = 7'(SH_CNT_MAX);
  localparam logic [4:0]        INVLD_MAX_C = 5'(SH_INVLD_MAX);
  localparam logic [W_WAIT-1:0] WAIT_LD_C   = W_WAIT'(SLIP_WAIT_HDRS);

  function automatic logic hdr_is_valid(input logic [W_SYNC-1:0] hdr);
    return (hdr == W_SYNC'(2'b01)) || (hdr == W_SYNC'(2'b10));
  endfunction

  logic [1:0]           state_q, state_d;
  logic [6:0]           sh_cnt_q, sh_cnt_d, sh_base_s;
  logic [4:0]           sh_invld_q, sh_invld_d, invld_base_s;
  logic [W_WAIT-1:0]    wait_q, wait_d;
  logic                 lock_q, lock_d;
  logic                 slip_q, slip_d;
  logic [W_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
  logic                 event_s, hdr_ok_s;

  assign event_s  = i_clk_en & i_grbx_hdr_valid;
  assign hdr_ok_s = hdr_is_valid(i_grbx_hdr);

  // Lock FSM; RESET_CNT is transient and evaluates the current event on zeroed counters
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    sh_invld_d   = sh_invld_q;
    wait_d       = wait_q;
    lock_d       = lock_q;
    slip_d       = slip_q;
    sh_base_s    = sh_cnt_q;
    invld_base_s = sh_invld_q;
    if (i_clk_en) begin
      slip_d = 1'b0;
      case (state_q)
        ST_RESET_CNT, ST_TEST_SH: begin
          if (state_q == ST_RESET_CNT) begin
            sh_base_s    = 7'd0;
            invld_base_s = 5'd0;
            wait_d       = '0;
          end else begin
            sh_base_s    = sh_cnt_q;
            invld_base_s = sh_invld_q;
          end
          state_d    = ST_TEST_SH;
          sh_cnt_d   = sh_base_s;
          sh_invld_d = invld_base_s;
          if (i_grbx_hdr_valid) begin
            sh_cnt_d = sh_base_s + 7'd1;
            if (hdr_ok_s) begin
              if (sh_cnt_d == SH_MAX_C) begin
                state_d = ST_RESET_CNT;
                if (invld_base_s == 5'd0) begin
                  lock_d = 1'b1;
                end else begin
                  lock_d = lock_q;
                end
              end else begin
                state_d = ST_TEST_SH;
              end
            end else begin
              sh_invld_d = invld_base_s + 5'd1;
              if ((sh_invld_d == INVLD_MAX_C) || !lock_q) begin
                state_d = ST_SLIP;
                lock_d  = 1'b0;
                slip_d  = 1'b1;
              end else if (sh_cnt_d == SH_MAX_C) begin
                state_d = ST_RESET_CNT;
              end else begin
                state_d = ST_TEST_SH;
              end
            end
          end else begin
            state_d = ST_TEST_SH;
          end
        end
        ST_SLIP: begin
          lock_d  = 1'b0;
          wait_d  = WAIT_LD_C;
          state_d = ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: begin
          if (i_grbx_hdr_valid) begin
            if (wait_q <= W_WAIT'(1)) begin
              wait_d  = '0;
              state_d = ST_RESET_CNT;
            end else begin
              wait_d = wait_q - W_WAIT'(1);
            end
          end else begin
            wait_d = wait_q;
          end
        end
        default: state_d = ST_RESET_CNT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating invalid-header counter; clear wins and ignores the clock enable
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_cnt_clr) begin
      err_cnt_d = '0;
    end else if (event_s && !hdr_ok_s && (err_cnt_q != {W_ERR_CNT{1'b1}})) begin
      err_cnt_d = err_cnt_q + W_ERR_CNT'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_RESET_CNT;
      sh_cnt_q   <= 7'd0;
      sh_invld_q <= 5'd0;
      wait_q     <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_invld_q <= sh_invld_d;
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_grbx_slip     = slip_q;
  assign o_block_lock    = lock_q;
  assign o_invld_hdr_cnt = err_cnt_q;

`ifdef ETH_PCS_BLOCK_SYNC_HI_BER_EN
  localparam int W_BER_CNT = $clog2(BER_THRESH + 1);
  localparam logic [14:0]          BER_WIN_END_C = 15'(BER_WIN_HDRS - 1);
  localparam logic [W_BER_CNT-1:0] BER_THR_C     = W_BER_CNT'(BER_THRESH);

  logic [14:0]          ber_win_q, ber_win_d;
  logic [W_BER_CNT-1:0] ber_cnt_q, ber_cnt_d;
  logic                 hi_ber_q, hi_ber_d;

  // BER window: flag sets early at threshold, is re-evaluated at window end
  always_comb begin
    ber_win_d = ber_win_q;
    ber_cnt_d = ber_cnt_q;
    hi_ber_d  = hi_ber_q;
    if (!lock_q || !lock_d) begin
      ber_win_d = 15'd0;
      ber_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end else if (event_s) begin
      if (!hdr_ok_s && (ber_cnt_q != BER_THR_C)) begin
        ber_cnt_d = ber_cnt_q + W_BER_CNT'(1);
      end else begin
        ber_cnt_d = ber_cnt_q;
      end
      if (ber_cnt_d == BER_THR_C) begin
        hi_ber_d = 1'b1;
      end else begin
        hi_ber_d = hi_ber_q;
      end
      if (ber_win_q == BER_WIN_END_C) begin
        hi_ber_d  = (ber_cnt_d == BER_THR_C);
        ber_win_d = 15'd0;
        ber_cnt_d = '0;
      end else begin
        ber_win_d = ber_win_q + 15'd1;
      end
    end else begin
      ber_win_d = ber_win_q;
    end
  end

  // BER registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ber_win_q <= 15'd0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      ber_win_q <= ber_win_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign o_hi_ber = hi_ber_q;
`else
  assign o_hi_ber = 1'b0;
`endif

endmodule
